// File: rtl/dice_pkg.sv
// Shared constants, state encoding and LFSR step function for the dice roller.
package dice_pkg;

    localparam int unsigned DIE_W    = 3;
    localparam int unsigned NUM_DICE = 6;
    localparam int unsigned LFSR_W   = 16;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1, as bit positions of the shift register.
    localparam int unsigned TAP_A = 15;
    localparam int unsigned TAP_B = 13;
    localparam int unsigned TAP_C = 12;
    localparam int unsigned TAP_D = 10;

    localparam logic [DIE_W-1:0] FACE_MIN = 3'd1;
    localparam logic [DIE_W-1:0] FACE_MAX = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        TUMBLE,
        DRAW,
        COMMIT
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

    // Low bits of the state the LFSR moves to on this edge.
    function automatic logic [DIE_W-1:0] next_sample(input logic [LFSR_W-1:0] s);
        return DIE_W'(lfsr_step(s));
    endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed is replaced by 1 to avoid lock-up.
module dice_lfsr
    import dice_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] SEED_EFF =
        (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else if (en) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/dice_roller.sv
// Six-die roller: LFSR rejection sampling into shadow registers, atomic commit to D1..D6.
// Optional DICE_LOADED_EN adds load/load_vals for forcing arbitrary faces while idle.
module dice_roller
    import dice_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
    parameter int unsigned       SETTLE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      roll,
`ifdef DICE_LOADED_EN
    input  logic                      load,
    input  logic [NUM_DICE*DIE_W-1:0] load_vals,
`endif
    output logic                      busy,
    output logic                      done,
    output logic                      dice_valid,
    output logic [DIE_W-1:0]          D1,
    output logic [DIE_W-1:0]          D2,
    output logic [DIE_W-1:0]          D3,
    output logic [DIE_W-1:0]          D4,
    output logic [DIE_W-1:0]          D5,
    output logic [DIE_W-1:0]          D6
);

    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    // The last die bypasses the shadow and commits straight from the sample.
    logic [DIE_W-1:0]          shadow_q [NUM_DICE-1];
    logic [DIE_W-1:0]          shadow_d [NUM_DICE-1];
    logic [NUM_DICE*DIE_W-1:0] faces_q, faces_d;
    logic                      done_q, done_d;
    logic                      valid_q, valid_d;

    logic [LFSR_W-1:0]         lfsr_state;
    logic [DIE_W-1:0]          sample;
    logic                      accept;

    dice_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr_state)
    );

    assign sample = next_sample(lfsr_state);
    assign accept = (sample >= FACE_MIN) && (sample <= FACE_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        faces_d  = faces_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE: begin
`ifdef DICE_LOADED_EN
                if (load) begin
                    faces_d = load_vals;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end else
`endif
                if (roll) begin
                    state_d = TUMBLE;
                    cnt_d   = 8'(SETTLE_CYCLES - 1);
                end
            end
            TUMBLE: begin
                if (cnt_q == '0) begin
                    state_d = DRAW;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DRAW: begin
                if (accept) begin
                    if (idx_q == 3'(NUM_DICE - 1)) begin
                        for (int i = 0; i < NUM_DICE - 1; i++) begin
                            faces_d[i*DIE_W +: DIE_W] = shadow_q[i];
                        end
                        faces_d[(NUM_DICE-1)*DIE_W +: DIE_W] = sample;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        idx_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        shadow_d[idx_q] = sample;
                        idx_d           = idx_q + 3'd1;
                    end
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '{default: '0};
            faces_q  <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            faces_q  <= faces_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign dice_valid = valid_q;
    assign D1         = faces_q[0*DIE_W +: DIE_W];
    assign D2         = faces_q[1*DIE_W +: DIE_W];
    assign D3         = faces_q[2*DIE_W +: DIE_W];
    assign D4         = faces_q[3*DIE_W +: DIE_W];
    assign D5         = faces_q[4*DIE_W +: DIE_W];
    assign D6         = faces_q[5*DIE_W +: DIE_W];

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: stimulus pushes predicted faces/latency, a monitor checks on done.
module tb_dice_roller;

    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          SETTLE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        roll = 1'b0;
    logic        busy, done, dice_valid;
    logic [2:0]  D1, D2, D3, D4, D5, D6;
`ifdef DICE_LOADED_EN
    logic        load = 1'b0;
    logic [17:0] load_vals = '0;
`endif

    always #5 clk = ~clk;

    dice_roller #(
        .SEED          (SEED),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .roll       (roll),
`ifdef DICE_LOADED_EN
        .load       (load),
        .load_vals  (load_vals),
`endif
        .busy       (busy),
        .done       (done),
        .dice_valid (dice_valid),
        .D1         (D1),
        .D2         (D2),
        .D3         (D3),
        .D4         (D4),
        .D5         (D5),
        .D6         (D6)
    );

    typedef struct {
        logic [17:0] faces;
        int          latency;
        int          issue;
        bit          is_roll;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          stab_err = 0;
    bit          armed = 1'b0;
    logic        rst_prev = 1'b1;
    logic [17:0] prev_d;
    logic [17:0] last_faces;
    logic [17:0] run1_faces;
    logic [15:0] m_lfsr;
    wire  [17:0] dut_faces = {D6, D5, D4, D3, D2, D1};

    // Reference LFSR written straight from the polynomial; steps every non-reset edge.
    function automatic logic [15:0] tb_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= tb_step(m_lfsr);
    end

    // l0 is the LFSR value in the cycle roll is sampled; first draw sees state SETTLE+2 on.
    function automatic exp_t predict(input logic [15:0] l0, input int issue);
        exp_t        e;
        logic [15:0] l;
        logic [2:0]  s;
        int          n;
        int          draws;
        l     = l0;
        n     = 0;
        draws = 0;
        e.faces = '0;
        for (int i = 0; i < SETTLE + 2; i++) l = tb_step(l);
        while (n < 6) begin
            s = l[2:0];
            draws++;
            if (s >= 3'd1 && s <= 3'd6) begin
                e.faces[n*3 +: 3] = s;
                n++;
            end
            l = tb_step(l);
        end
        e.latency = SETTLE + 1 + draws;
        e.issue   = issue;
        e.is_roll = 1'b1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (!rst_prev && !done && dut_faces !== prev_d) stab_err++;
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: done=1 with faces %0h, expected no done", dut_faces);
                end else begin
                    mon_e = sb.pop_front();
                    chk("faces", 32'(dut_faces), 32'(mon_e.faces));
                    chk("done_latency", cyc - mon_e.issue, mon_e.latency);
                    chk("dice_valid_at_done", 32'(dice_valid), 32'd1);
                    if (mon_e.is_roll) begin
                        logic ok;
                        ok = 1'b1;
                        for (int i = 0; i < 6; i++)
                            if (dut_faces[i*3 +: 3] == 3'd0 || dut_faces[i*3 +: 3] == 3'd7) ok = 1'b0;
                        chk("faces_in_range", 32'(ok), 32'd1);
                    end
                    last_faces = dut_faces;
                end
            end
        end
        prev_d   = dut_faces;
        rst_prev = rst;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_roll();
        sb.push_back(predict(m_lfsr, cyc));
        roll = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d pending after %0d cycles, expected 0", sb.size(), budget);
            sb.delete();
        end
    endtask

`ifdef DICE_LOADED_EN
    task automatic issue_load(input logic [17:0] vals);
        exp_t e;
        e.faces   = vals;
        e.latency = 1;
        e.issue   = cyc;
        e.is_roll = 1'b0;
        sb.push_back(e);
        load_vals = vals;
        load      = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        int w;

        // Reset state
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_D1", 32'(D1), 0);
        chk("rst_D2", 32'(D2), 0);
        chk("rst_D3", 32'(D3), 0);
        chk("rst_D4", 32'(D4), 0);
        chk("rst_D5", 32'(D5), 0);
        chk("rst_D6", 32'(D6), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dice_valid", 32'(dice_valid), 0);
        armed = 1'b1;

        // Basic roll, run 1
        tick(3);
        issue_roll();
        tick();
        roll = 1'b0;
        chk("busy_after_roll", 32'(busy), 1);
        wait_drain(60);
        run1_faces = last_faces;
        tick(2);
        chk("busy_after_commit", 32'(busy), 0);

        // Same timing from reset gives identical faces
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        sb.delete();
        tick(3);
        issue_roll();
        tick();
        roll = 1'b0;
        wait_drain(60);
        chk("repeatable_faces", 32'(last_faces), 32'(run1_faces));

        // Roll held high through three back-to-back rolls
        tick(2);
        dc0  = done_count;
        roll = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (busy && w < 60) begin
                tick();
                w++;
            end
            if (k > 0) chk("waited_through_roll", 32'(w > 0), 1);
            sb.push_back(predict(m_lfsr, cyc));
            tick();
            if (k == 2) roll = 1'b0;
            chk("busy_low_one_cycle", 32'(busy), 1);
        end
        wait_drain(60);
        tick(2);
        chk("three_done_pulses", done_count - dc0, 3);

        // Roll request while busy is dropped
        dc0 = done_count;
        issue_roll();
        tick();
        roll = 1'b0;
        tick(3);
        roll = 1'b1;
        tick();
        roll = 1'b0;
        wait_drain(60);
        tick(30);
        chk("single_done", done_count - dc0, 1);
        chk("no_restart", 32'(busy), 0);

        // Reset during DRAW aborts the roll
        issue_roll();
        tick();
        roll = 1'b0;
        tick(SETTLE + 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_faces", 32'(dut_faces), 0);
        chk("midrst_dice_valid", 32'(dice_valid), 0);
        chk("midrst_done", 32'(done), 0);
        tick(2);
        issue_roll();
        tick();
        roll = 1'b0;
        wait_drain(60);
        chk("fresh_roll_valid", 32'(dice_valid), 1);

`ifdef DICE_LOADED_EN
        // Loaded faces
        tick(2);
        issue_load({3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4});
        tick();
        load = 1'b0;
        chk("load_D1", 32'(D1), 4);
        chk("load_D5", 32'(D5), 4);
        chk("load_D6", 32'(D6), 2);
        wait_drain(5);
        issue_load({3'd2, 3'd7, 3'd4, 3'd4, 3'd4, 3'd4});
        tick();
        load = 1'b0;
        chk("load_D5_seven", 32'(D5), 7);
        wait_drain(5);
        // Load wins over roll
        issue_load({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1});
        roll = 1'b1;
        tick();
        load = 1'b0;
        roll = 1'b0;
        chk("load_priority_busy", 32'(busy), 0);
        wait_drain(5);
        // Load while busy is ignored
        issue_roll();
        tick();
        roll = 1'b0;
        tick(2);
        load_vals = '0;
        load      = 1'b1;
        tick();
        load = 1'b0;
        wait_drain(60);
`endif

        tick(2);
        chk("faces_stable_between_commits", stab_err, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dice_roller.md
# dice_roller

Sequential dice source for the prize-selector datapath. It draws six independent die faces (1..6) from a free-running 16-bit LFSR using rejection sampling. It presents the faces on D1..D6, the same 3-bit-per-die encoding the `Main` prize selector consumes. Faces update atomically on commit, so the downstream combinational selector never sees a partially updated roll.

## Interface
Parameters:
- SEED, 16'hACE1, LFSR reset value; a SEED of 0 is replaced by 16'h0001.
- SETTLE_CYCLES, 8, tumble cycles before drawing starts; range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- roll  in  1  roll request; sampled only in IDLE.
- busy  out  1  high while a roll is in progress.
- done  out  1  one-cycle pulse when new faces are committed.
- dice_valid  out  1  high once D1..D6 hold a completed roll or a load.
- D1..D6  out  3 each  committed die faces; same encoding as the selector inputs.

## Operation
- LFSR: Fibonacci, x^16+x^14+x^13+x^11+1. Each step shifts left, and bit0 = s[15]^s[13]^s[12]^s[10]. It steps every cycle in every state except reset, so the user's timing of `roll` adds entropy.
- States: IDLE, TUMBLE, DRAW, COMMIT.
  - IDLE, roll=1 → TUMBLE; settle counter loaded with SETTLE_CYCLES-1.
  - TUMBLE: counter decrements each cycle; at 0 → DRAW, with die index idx=0.
  - DRAW: sample = new LFSR state [2:0] each cycle. If sample is in 1..6, write it to shadow[idx] and increment idx; 0 and 7 are rejected. When the write to idx=5 is accepted → COMMIT.
  - COMMIT: D1..D6 ← shadow[0..5], done=1, dice_valid=1 → IDLE.
- `roll` while busy is ignored; it is not queued.
- D1..D6 hold their previous values throughout TUMBLE and DRAW.
- Reset values: D1..D6=3'd0, busy=0, done=0, dice_valid=0, state=IDLE, idx=0, LFSR=SEED.
- Reset mid-roll aborts the roll. The shadow contents are discarded and the outputs take their reset values on the next edge.

## Timing
- Cycle 0: roll high in IDLE. Cycle 1: busy=1 (TUMBLE).
- DRAW begins at cycle 1+SETTLE_CYCLES.
- Each accepted sample takes exactly one DRAW cycle. Minimum DRAW time is 6 cycles; the acceptance rate is 6/8 per cycle.
- COMMIT is one cycle. D1..D6, done and dice_valid all change on the COMMIT edge. busy falls on the following edge, together with the return to IDLE.
- Minimum roll-to-done latency: SETTLE_CYCLES+7 cycles.
- A new roll may be accepted in the first IDLE cycle after COMMIT.
- The LFSR never reaches the all-zero state, so every roll terminates.

## Configuration
- DICE_LOADED_EN defined adds two ports:
  - load  in  1
  - load_vals  in  18, holding D1 in [2:0] through D6 in [17:15].
- Behaviour with DICE_LOADED_EN:
  - In IDLE, load=1 writes load_vals verbatim to D1..D6 on the next edge. Values 0 and 7 are permitted, so the selector's invalid-face handling can be exercised.
  - The same load also sets dice_valid=1 and pulses done for one cycle.
  - load has priority over roll in the same cycle.
  - load is ignored while busy.
- Without DICE_LOADED_EN: neither port exists, and D1..D6 only ever carry values 1..6 or the reset value 0.

## Structure
- Shared package `dice_pkg`: DIE_W=3, NUM_DICE=6, LFSR_W=16, tap constants, the state enum (IDLE/TUMBLE/DRAW/COMMIT), and FACE_MIN=1 / FACE_MAX=6.
- One sub-module, `dice_lfsr`: seed parameter, step enable tied high, 16-bit state output.
- The FSM, counters, shadow registers and output registers stay in `dice_roller`.

## Test plan
- Reset check: hold rst 2 cycles → D1..D6=0, busy=0, done=0, dice_valid=0.
- Basic roll: with SETTLE_CYCLES=8, pulse roll one cycle.
  - busy=1 one cycle later.
  - done pulses once, no earlier than 15 cycles after roll.
  - Every Dn is in 1..6, and dice_valid=1.
  - D1..D6 are unchanged until that done edge.
- Repeat roll: hold roll high through 3 consecutive rolls → exactly 3 done pulses, with busy low for exactly one cycle between rolls. Two runs from reset with identical roll timing produce identical faces.
- Ignored request: pulse roll again 4 cycles into a roll → still only one done. No second roll starts after it.
- Reset mid-roll: assert rst during DRAW → next cycle busy=0, D1..D6=0, dice_valid=0. A fresh roll afterwards completes normally.
- DICE_LOADED_EN load: in IDLE, load=1 with load_vals for faces 4,4,4,4,4,2 → next cycle D1..D5=4, D6=2, done pulse. Then load D5=7 → D5=7. Load while busy → ignored.
